// File: rtl/bus_ctrl_path_if.sv
// Bundle of the arbiter/bus-control signals between two masters, the controller and three slaves.
// The controller binds to the master modport; the environment driving it uses the slave modport.
interface bus_ctrl_path_if;
  logic        busreq_1;
  logic        busreq_2;
  logic        read_write;
  logic        ready;
  logic        split;
  logic [1:0]  response;
  logic [15:0] data_in1;
  logic [15:0] data_in2;
  logic [31:0] data_in3;
  logic [31:0] data_in4;
  logic [31:0] rdin1;
  logic [31:0] rdin2;
  logic [31:0] rdin3;
  logic [1:0]  resp1;
  logic [1:0]  resp2;
  logic [1:0]  resp3;
  logic        rdy1;
  logic        rdy2;
  logic        rdy3;

  logic        grant_1;
  logic        grant_2;
  logic        error;
  logic [15:0] address;
  logic        slave_0;
  logic        slave_1;
  logic        slave_2;
  logic [31:0] dataout;
  logic [31:0] dout;
  logic [1:0]  respout;
  logic        rdyout;

  modport master (
    input  busreq_1, busreq_2, read_write, ready, split, response,
    input  data_in1, data_in2, data_in3, data_in4,
    input  rdin1, rdin2, rdin3, resp1, resp2, resp3, rdy1, rdy2, rdy3,
    output grant_1, grant_2, error, address, slave_0, slave_1, slave_2,
    output dataout, dout, respout, rdyout
  );

  modport slave (
    output busreq_1, busreq_2, read_write, ready, split, response,
    output data_in1, data_in2, data_in3, data_in4,
    output rdin1, rdin2, rdin3, resp1, resp2, resp3, rdy1, rdy2, rdy3,
    input  grant_1, grant_2, error, address, slave_0, slave_1, slave_2,
    input  dataout, dout, respout, rdyout
  );
endinterface

// File: rtl/bus_ctrl_path.sv
// Two-master bus controller: fixed-priority arbitration, address/data phases, slave decode,
// response handling (OKAY/ERROR/RETRY/SPLIT) and a combinational read-return mux.
module bus_ctrl_path (
  input logic             clk,
  input logic             rst,
  bus_ctrl_path_if.master bus_io
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StAddr = 2'b01;
  localparam logic [1:0] StData = 2'b10;
  localparam logic [1:0] StErr  = 2'b11;

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;
  localparam logic [1:0] RespRetry = 2'b10;
  localparam logic [1:0] RespSplit = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        grant_1_q, grant_1_d;
  logic        grant_2_q, grant_2_d;
  logic [15:0] address_q, address_d;
  logic [31:0] dataout_q, dataout_d;
  logic        wr_loaded_q, wr_loaded_d;
  logic [2:0]  slave_sel;

  always_comb begin
    state_d     = state_q;
    grant_1_d   = grant_1_q;
    grant_2_d   = grant_2_q;
    address_d   = address_q;
    dataout_d   = dataout_q;
    wr_loaded_d = wr_loaded_q;

    case (state_q)
      StIdle: begin
        if (bus_io.busreq_1) begin
          state_d   = StAddr;
          grant_1_d = 1'b1;
          grant_2_d = 1'b0;
        end else if (bus_io.busreq_2) begin
          state_d   = StAddr;
          grant_1_d = 1'b0;
          grant_2_d = 1'b1;
        end
      end

      StAddr: begin
        if (grant_1_q) begin
          address_d = bus_io.data_in1;
        end else if (grant_2_q) begin
          address_d = bus_io.data_in2;
        end
        wr_loaded_d = 1'b0;
        state_d     = StData;
      end

      StData: begin
        // Write data is captured once per data phase, on the first cycle that sees a write.
        if (bus_io.read_write && !wr_loaded_q) begin
          dataout_d   = grant_1_q ? bus_io.data_in3 : bus_io.data_in4;
          wr_loaded_d = 1'b1;
        end
        if (bus_io.split) begin
          state_d = StIdle;
        end else if (bus_io.ready) begin
          case (bus_io.response)
            RespOkay:  state_d = StIdle;
            RespError: state_d = StErr;
            RespRetry: state_d = StAddr;
            RespSplit: state_d = StIdle;
            default:   state_d = StIdle;
          endcase
        end
      end

      StErr: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Ownership ends whenever the bus returns to idle.
    if (state_d == StIdle) begin
      grant_1_d = 1'b0;
      grant_2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_1_q   <= 1'b0;
      grant_2_q   <= 1'b0;
      address_q   <= '0;
      dataout_q   <= '0;
      wr_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_1_q   <= grant_1_d;
      grant_2_q   <= grant_2_d;
      address_q   <= address_d;
      dataout_q   <= dataout_d;
      wr_loaded_q <= wr_loaded_d;
    end
  end

  always_comb begin
    slave_sel = 3'b000;
    if (state_q == StData) begin
      case (address_q[15:13])
        3'd0:    slave_sel = 3'b001;
        3'd1:    slave_sel = 3'b010;
        3'd2:    slave_sel = 3'b100;
        default: slave_sel = 3'b000;
      endcase
    end
  end

  // Read return defaults to an idle OKAY/ready bus when nothing is being read.
  always_comb begin
    bus_io.dout    = '0;
    bus_io.respout = RespOkay;
    bus_io.rdyout  = 1'b1;
    if (!bus_io.read_write) begin
      unique case (slave_sel)
        3'b001: begin
          bus_io.dout    = bus_io.rdin1;
          bus_io.respout = bus_io.resp1;
          bus_io.rdyout  = bus_io.rdy1;
        end
        3'b010: begin
          bus_io.dout    = bus_io.rdin2;
          bus_io.respout = bus_io.resp2;
          bus_io.rdyout  = bus_io.rdy2;
        end
        3'b100: begin
          bus_io.dout    = bus_io.rdin3;
          bus_io.respout = bus_io.resp3;
          bus_io.rdyout  = bus_io.rdy3;
        end
        default: begin
          bus_io.dout    = '0;
          bus_io.respout = RespOkay;
          bus_io.rdyout  = 1'b1;
        end
      endcase
    end
  end

  assign bus_io.grant_1 = grant_1_q;
  assign bus_io.grant_2 = grant_2_q;
  assign bus_io.error   = (state_q == StErr);
  assign bus_io.address = address_q;
  assign bus_io.slave_0 = slave_sel[0];
  assign bus_io.slave_1 = slave_sel[1];
  assign bus_io.slave_2 = slave_sel[2];
  assign bus_io.dataout = dataout_q;

endmodule

// File: tb/tb_bus_ctrl_path.sv
// Self-checking bench for bus_ctrl_path: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the bus protocol.
module tb_bus_ctrl_path;

  logic clk;
  logic rst;

  bus_ctrl_path_if bus ();

  bus_ctrl_path dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: which phase the bus is in, who owns it, and the registered bus values.
  typedef enum int {PIdle, PAddr, PData, PErr} phase_t;
  phase_t      m_phase;
  int          m_owner;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_wr_taken;

  task automatic model_reset();
    m_phase    = PIdle;
    m_owner    = 0;
    m_addr     = '0;
    m_wdata    = '0;
    m_wr_taken = 0;
  endtask

  task automatic model_clock();
    case (m_phase)
      PIdle: begin
        if (bus.busreq_1) begin m_owner = 1; m_phase = PAddr; end
        else if (bus.busreq_2) begin m_owner = 2; m_phase = PAddr; end
      end
      PAddr: begin
        m_addr     = (m_owner == 1) ? bus.data_in1 : bus.data_in2;
        m_wr_taken = 0;
        m_phase    = PData;
      end
      PData: begin
        if (bus.read_write && !m_wr_taken) begin
          m_wdata    = (m_owner == 1) ? bus.data_in3 : bus.data_in4;
          m_wr_taken = 1;
        end
        if (bus.split) m_phase = PIdle;
        else if (bus.ready) begin
          if (bus.response == 2'b01) m_phase = PErr;
          else if (bus.response == 2'b10) m_phase = PAddr;
          else m_phase = PIdle;
        end
      end
      PErr: m_phase = PIdle;
      default: m_phase = PIdle;
    endcase
    if (m_phase == PIdle) m_owner = 0;
  endtask

  task automatic compare_model();
    int          sel;
    logic [31:0] e_dout;
    logic [1:0]  e_resp;
    logic        e_rdy;
    logic [2:0]  e_sel;
    sel = -1;
    if (m_phase == PData && m_addr[15:13] < 3) sel = int'(m_addr[15:13]);
    e_sel  = {sel == 2, sel == 1, sel == 0};
    e_dout = '0;
    e_resp = 2'b00;
    e_rdy  = 1'b1;
    if (m_phase == PData && !bus.read_write) begin
      if (sel == 0) begin e_dout = bus.rdin1; e_resp = bus.resp1; e_rdy = bus.rdy1; end
      if (sel == 1) begin e_dout = bus.rdin2; e_resp = bus.resp2; e_rdy = bus.rdy2; end
      if (sel == 2) begin e_dout = bus.rdin3; e_resp = bus.resp3; e_rdy = bus.rdy3; end
    end
    check("grants", {bus.grant_2, bus.grant_1}, {m_owner == 2, m_owner == 1});
    check("error", bus.error, m_phase == PErr);
    check("address", bus.address, m_addr);
    check("selects", {bus.slave_2, bus.slave_1, bus.slave_0}, e_sel);
    check("dataout", bus.dataout, m_wdata);
    check("dout", bus.dout, e_dout);
    check("respout", bus.respout, e_resp);
    check("rdyout", bus.rdyout, e_rdy);
  endtask

  // Inputs are driven just after a falling edge; tick compares, advances the model, and waits.
  task automatic tick();
    #1;
    compare_model();
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.busreq_1 = 0; bus.busreq_2 = 0; bus.read_write = 0; bus.ready = 0; bus.split = 0;
    bus.response = 2'b00; bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
    bus.data_in4 = '0; bus.rdin1 = '0; bus.rdin2 = '0; bus.rdin3 = '0;
    bus.resp1 = '0; bus.resp2 = '0; bus.resp3 = '0; bus.rdy1 = 0; bus.rdy2 = 0; bus.rdy3 = 0;
  endtask

  task automatic drive_random();
    bus.busreq_1   = ($urandom_range(0, 9) < 4);
    bus.busreq_2   = ($urandom_range(0, 9) < 4);
    bus.read_write = $urandom_range(0, 1);
    bus.ready      = $urandom_range(0, 1);
    bus.split      = ($urandom_range(0, 11) == 0);
    bus.response   = 2'($urandom_range(0, 3));
    bus.data_in1   = {3'($urandom_range(0, 7)), 13'($urandom)};
    bus.data_in2   = {3'($urandom_range(0, 7)), 13'($urandom)};
    bus.data_in3   = $urandom;
    bus.data_in4   = $urandom;
    bus.rdin1 = $urandom; bus.rdin2 = $urandom; bus.rdin3 = $urandom;
    bus.resp1 = 2'($urandom); bus.resp2 = 2'($urandom); bus.resp3 = 2'($urandom);
    bus.rdy1 = $urandom_range(0, 1); bus.rdy2 = $urandom_range(0, 1);
    bus.rdy3 = $urandom_range(0, 1);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Quiet bus after reset.
    repeat (20) tick();
    check("idle_grants", {bus.grant_2, bus.grant_1}, 2'b00);
    check("idle_error", bus.error, 1'b0);
    check("idle_address", bus.address, 16'h0000);
    check("idle_selects", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b000);

    // Master 1 write to slave 1.
    bus.busreq_1 = 1; bus.data_in1 = 16'h2008; bus.data_in3 = 32'd567;
    bus.read_write = 1; bus.ready = 1; bus.response = 2'b00;
    tick();
    check("m1w_grant", {bus.grant_2, bus.grant_1}, 2'b01);
    tick();
    check("m1w_address", bus.address, 16'h2008);
    check("m1w_slave1", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b010);
    bus.busreq_1 = 0;
    tick();
    check("m1w_dataout", bus.dataout, 32'd567);
    check("m1w_idle", {bus.grant_2, bus.grant_1}, 2'b00);
    tick();

    // Master 2 read from slave 2.
    drive_idle();
    bus.busreq_2 = 1; bus.data_in2 = 16'h4008; bus.read_write = 0; bus.ready = 1;
    bus.rdin3 = 32'd50; bus.resp3 = 2'b00; bus.rdy3 = 1;
    tick();
    check("m2r_grant", {bus.grant_2, bus.grant_1}, 2'b10);
    tick();
    check("m2r_slave2", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b100);
    check("m2r_dout", bus.dout, 32'd50);
    check("m2r_respout", bus.respout, 2'b00);
    check("m2r_rdyout", bus.rdyout, 1'b1);
    bus.busreq_2 = 0;
    tick();

    // Contention: master 1 first, master 2 after one idle cycle.
    bus.busreq_1 = 1; bus.busreq_2 = 1; bus.data_in1 = 16'h0011; bus.data_in2 = 16'h2222;
    bus.response = 2'b00;
    tick();
    check("cont_grant1", {bus.grant_2, bus.grant_1}, 2'b01);
    tick();
    check("cont_addr1", bus.address, 16'h0011);
    bus.busreq_1 = 0;
    tick();
    check("cont_gap", {bus.grant_2, bus.grant_1}, 2'b00);
    tick();
    check("cont_grant2", {bus.grant_2, bus.grant_1}, 2'b10);
    tick();
    check("cont_addr2", bus.address, 16'h2222);
    bus.busreq_2 = 0;
    tick();

    // ERROR response.
    bus.busreq_1 = 1; bus.data_in1 = 16'h0000; bus.response = 2'b01;
    tick();
    bus.busreq_1 = 0;
    tick();
    tick();
    check("err_pulse", bus.error, 1'b1);
    tick();
    check("err_cleared", bus.error, 1'b0);
    check("err_grants", {bus.grant_2, bus.grant_1}, 2'b00);

    // RETRY response re-issues the same master's address.
    bus.busreq_1 = 1; bus.data_in1 = 16'h2345; bus.response = 2'b10;
    tick();
    bus.busreq_1 = 0;
    tick();
    check("retry_addr", bus.address, 16'h2345);
    tick();
    check("retry_grant", {bus.grant_2, bus.grant_1}, 2'b01);
    check("retry_nosel", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b000);
    tick();
    check("retry_addr2", bus.address, 16'h2345);
    bus.response = 2'b00;
    tick();

    // SPLIT while waiting on ready.
    bus.busreq_2 = 1; bus.data_in2 = 16'h0100; bus.ready = 0; bus.split = 0;
    tick();
    bus.busreq_2 = 0;
    tick();
    tick();
    check("split_wait", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b001);
    bus.split = 1;
    tick();
    check("split_grants", {bus.grant_2, bus.grant_1}, 2'b00);
    check("split_nosel", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b000);
    bus.split = 0;

    // Asynchronous reset in the middle of a write data phase.
    bus.busreq_1 = 1; bus.data_in1 = 16'h2008; bus.data_in3 = 32'hABCD; bus.read_write = 1;
    bus.ready = 0;
    tick();
    bus.busreq_1 = 0;
    tick();
    tick();
    check("pre_rst_dataout", bus.dataout, 32'hABCD);
    #2 rst = 1'b0;
    #1;
    check("rst_grants", {bus.grant_2, bus.grant_1}, 2'b00);
    check("rst_address", bus.address, 16'h0000);
    check("rst_dataout", bus.dataout, 32'h0);
    check("rst_selects", {bus.slave_2, bus.slave_1, bus.slave_0}, 3'b000);
    check("rst_error", bus.error, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    tick();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      if ($urandom_range(0, 149) == 0) begin
        #3 rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
